// File: rtl/adc_frame_packer_if.sv
// ---------------------------------------------------------------------------
// adc_frame_packer_if
//   32-bit valid/ready output stream of the ADC frame packer.
//   master : producer (drives data/valid/last, samples ready)
//   slave  : consumer (samples data/valid/last, drives ready)
// Signals
//   out_data   32  stream word
//   out_valid   1  word present
//   out_ready   1  consumer accepts word this cycle
//   out_last    1  final (trailer) word of a frame
// ---------------------------------------------------------------------------
interface adc_frame_packer_if;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/adc_frame_packer.sv
// ---------------------------------------------------------------------------
// adc_frame_packer
//   Pops one 128-bit word from each of the four AD9252 data FIFOs at the same
//   time, checks the per-ADC header (EEAA/EEBB/EECC/EEDD) and serialises the
//   512-bit snapshot into an 18-word frame on a 32-bit valid/ready stream:
//     w0      {A5A5, frame_cnt}
//     w1..w16 A,B,C,D words, each MSB-first in four 32-bit slices
//     w17     {000, hdr_err[3:0], 5A5A}  (out_last)
// Ports
//   fifo_rd_clk        clock (FIFO read side and output stream)
//   reset_n            asynchronous active-low reset
//   enable             allow new frames (looked at only in IDLE)
//   data_aligned       all four ADCs aligned (gates frame start if ALIGN_REQ)
//   fifo_empty_i[3:0]  per-FIFO empty, [0]=A..[3]=D
//   fifo_rden[3:0]     per-FIFO read enable, registered one-cycle pulse
//   adc_*_data_para    FIFO douts, valid the cycle after the rden pulse
//   out_if             output stream (master side)
//   frame_cnt          frames fully sent, wraps
//   hdr_err_cnt        frames with at least one bad header, saturates
//   busy               FSM not in IDLE
// ---------------------------------------------------------------------------

// Per-ADC capture lane: holds one FIFO word and its header verdict.
module adc_lane_capt #(
    parameter logic [15:0] HDR_EXP = 16'hEEAA
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_capt,
    input  logic [127:0] i_dout,
    output logic         o_hdr_bad,  // combinational verdict on i_dout
    output logic [127:0] o_word,
    output logic         o_hdr_err   // registered verdict for the held word
);
    logic [127:0] r_word;
    logic         r_hdr_err;
    logic         w_hdr_bad;

    assign w_hdr_bad = (i_dout[127:112] != HDR_EXP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word    <= '0;
            r_hdr_err <= 1'b0;
        end else if (i_capt) begin
            r_word    <= i_dout;
            r_hdr_err <= w_hdr_bad;
        end
    end

    assign o_hdr_bad = w_hdr_bad;
    assign o_word    = r_word;
    assign o_hdr_err = r_hdr_err;
endmodule

module adc_frame_packer #(
    parameter bit ALIGN_REQ = 1'b1,
    parameter int FRM_CNT_W = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 fifo_rd_clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 data_aligned,
    input  logic [3:0]           fifo_empty_i,
    output logic [3:0]           fifo_rden,
    input  logic [127:0]         adc_a_data_para,
    input  logic [127:0]         adc_b_data_para,
    input  logic [127:0]         adc_c_data_para,
    input  logic [127:0]         adc_d_data_para,
    adc_frame_packer_if.master   out_if,
    output logic [FRM_CNT_W-1:0] frame_cnt,
    output logic [ERR_CNT_W-1:0] hdr_err_cnt,
    output logic                 busy
);
    localparam int NUM_ADC  = 4;
    localparam logic [4:0] LAST_IDX = 5'd17;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_CAPT = 2'd2,
        S_SEND = 2'd3
    } state_t;

    state_t                         r_state;
    logic [4:0]                     r_idx;
    logic [3:0]                     r_rden;
    logic [31:0]                    r_data;
    logic                           r_valid;
    logic                           r_last;
    logic [FRM_CNT_W-1:0]           r_frame_cnt;
    logic [ERR_CNT_W-1:0]           r_err_cnt;
    logic                           r_busy;

    logic [NUM_ADC-1:0][127:0]      w_dout;
    logic [NUM_ADC-1:0][127:0]      w_cap;
    logic [NUM_ADC-1:0]             w_hdr_bad;
    logic [NUM_ADC-1:0]             w_hdr_err;
    logic [15:0][31:0]              w_words;
    logic                           w_start;
    logic                           w_accept;
    logic                           w_capt;
    logic [4:0]                     w_next_idx;
    logic [3:0]                     w_sel;
    logic [31:0]                    w_next_word;

    assign w_dout = {adc_d_data_para, adc_c_data_para, adc_b_data_para, adc_a_data_para};
    assign w_capt = (r_state == S_CAPT);

    // FIFO dout is valid during CAPT (one cycle after the READ pulse), so the
    // lanes load on the CAPT->SEND edge.
    for (genvar g = 0; g < NUM_ADC; g++) begin : g_lane
        adc_lane_capt #(
            .HDR_EXP (16'hEEAA + 16'(g) * 16'h0011)
        ) u_lane (
            .clk       (fifo_rd_clk),
            .rst_n     (reset_n),
            .i_capt    (w_capt),
            .i_dout    (w_dout[g]),
            .o_hdr_bad (w_hdr_bad[g]),
            .o_word    (w_cap[g]),
            .o_hdr_err (w_hdr_err[g])
        );
    end

    // Element 15 is A[127:96] (w1), element 0 is D[31:0] (w16): word m of the
    // frame (1..16) sits at element 16-m.
    assign w_words = {w_cap[0], w_cap[1], w_cap[2], w_cap[3]};

    assign w_start    = enable && (fifo_empty_i == 4'b0000) &&
                        (data_aligned || !ALIGN_REQ);
    assign w_accept   = r_valid && out_if.out_ready;
    assign w_next_idx = r_idx + 5'd1;
    assign w_sel      = 4'(5'd16 - w_next_idx);

    always_comb begin
        w_next_word = '0;
        if (w_next_idx == LAST_IDX)
            w_next_word = {12'h000, w_hdr_err, 16'h5A5A};
        else
            w_next_word = w_words[w_sel];
    end

    // Output word is registered: it is loaded with the next word on each
    // accept, so it holds still while the consumer stalls.
    always_ff @(posedge fifo_rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_rden      <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_READ;
                        r_rden  <= 4'hF;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    r_rden  <= 4'h0;
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    r_state <= S_SEND;
                    r_idx   <= '0;
                    r_valid <= 1'b1;
                    r_last  <= 1'b0;
                    r_data  <= {16'hA5A5, 16'(r_frame_cnt)};
                    if ((|w_hdr_bad) && (r_err_cnt != {ERR_CNT_W{1'b1}}))
                        r_err_cnt <= r_err_cnt + 1'b1;
                end
                S_SEND: begin
                    if (w_accept) begin
                        if (r_idx == LAST_IDX) begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                            r_state     <= S_IDLE;
                            r_idx       <= '0;
                            r_valid     <= 1'b0;
                            r_last      <= 1'b0;
                            r_data      <= '0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_idx  <= w_next_idx;
                            r_data <= w_next_word;
                            r_last <= (w_next_idx == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rden  <= '0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rden        = r_rden;
    assign out_if.out_data  = r_data;
    assign out_if.out_valid = r_valid;
    assign out_if.out_last  = r_last;
    assign frame_cnt        = r_frame_cnt;
    assign hdr_err_cnt      = r_err_cnt;
    assign busy             = r_busy;
endmodule

// File: tb/tb_adc_frame_packer.sv
module tb_adc_frame_packer;
    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         enable = 1'b0;
    logic         data_aligned = 1'b0;
    logic [3:0]   fifo_empty = 4'hF;
    logic [3:0]   fifo_rden;
    logic [127:0] dout [4];
    logic [15:0]  frame_cnt;
    logic [7:0]   hdr_err_cnt;
    logic         busy;

    adc_frame_packer_if sif ();

    adc_frame_packer #(.ALIGN_REQ(1'b1), .FRM_CNT_W(16), .ERR_CNT_W(8)) dut (
        .fifo_rd_clk     (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .data_aligned    (data_aligned),
        .fifo_empty_i    (fifo_empty),
        .fifo_rden       (fifo_rden),
        .adc_a_data_para (dout[0]),
        .adc_b_data_para (dout[1]),
        .adc_c_data_para (dout[2]),
        .adc_d_data_para (dout[3]),
        .out_if          (sif),
        .frame_cnt       (frame_cnt),
        .hdr_err_cnt     (hdr_err_cnt),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // FIFO models: dout updates on the edge that samples rden
    logic [127:0] qa[$], qb[$], qc[$], qd[$];
    logic [127:0] held_c;

    initial begin
        for (int i = 0; i < 4; i++) dout[i] = '0;
    end

    always @(posedge clk) begin
        if (fifo_rden[0] && qa.size() > 0) dout[0] <= qa.pop_front();
        if (fifo_rden[1] && qb.size() > 0) dout[1] <= qb.pop_front();
        if (fifo_rden[2] && qc.size() > 0) dout[2] <= qc.pop_front();
        if (fifo_rden[3] && qd.size() > 0) dout[3] <= qd.pop_front();
        fifo_empty <= {qd.size() == 0, qc.size() == 0, qb.size() == 0, qa.size() == 0};
    end

    // Scoreboard of expected {last, data}
    logic [32:0] exq[$];
    logic [15:0] mdl_cnt = 16'h0000;

    function automatic logic [127:0] mk(input logic [15:0] hdr, input int lane, input int seed);
        return {hdr, 16'(lane), 32'(seed), 32'hC0DE_0000 ^ 32'(seed), 32'(seed) * 32'h0000_9E37};
    endfunction

    task automatic push_frame(input logic [15:0] ha, hb, hc, hd, input int seed, input bit hold_c);
        logic [127:0] w [4];
        logic [3:0]   e;
        w[0] = mk(ha, 0, seed);
        w[1] = mk(hb, 1, seed);
        w[2] = mk(hc, 2, seed);
        w[3] = mk(hd, 3, seed);
        qa.push_back(w[0]);
        qb.push_back(w[1]);
        if (hold_c) held_c = w[2];
        else qc.push_back(w[2]);
        qd.push_back(w[3]);
        e = {hd != 16'hEEDD, hc != 16'hEECC, hb != 16'hEEBB, ha != 16'hEEAA};
        exq.push_back({1'b0, 16'hA5A5, mdl_cnt});
        for (int l = 0; l < 4; l++) begin
            exq.push_back({1'b0, w[l][127:96]});
            exq.push_back({1'b0, w[l][95:64]});
            exq.push_back({1'b0, w[l][63:32]});
            exq.push_back({1'b0, w[l][31:0]});
        end
        exq.push_back({1'b1, 12'h000, e, 16'h5A5A});
        mdl_cnt = mdl_cnt + 16'h1;
    endtask

    // Ready driver: constant 1, or toggling every cycle
    bit rdy_toggle = 1'b0;
    initial begin
        sif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            sif.out_ready = rdy_toggle ? ~sif.out_ready : 1'b1;
        end
    end

    // Output monitor (between edges)
    int          cyc = 0;
    bit          hold_vld = 1'b0;
    logic [32:0] hold_w;
    logic [32:0] exp_w;
    int          acc_in_frm = 0;
    int          rden_pulses = 0;
    bit          prev_valid = 1'b0;
    bit          seen_frame = 1'b0;
    int          idle_gap = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            hold_vld   = 1'b0;
            prev_valid = 1'b0;
            acc_in_frm = 0;
        end else begin
            if (|fifo_rden) begin
                rden_pulses++;
                chk("rden_on_empty", 64'(fifo_rden & fifo_empty), 64'h0);
            end
            if (sif.out_valid) begin
                if (!prev_valid && seen_frame) chk("frame_gap_ge3", 64'(idle_gap >= 3), 64'h1);
                if (hold_vld) chk("stall_stable", {31'h0, sif.out_last, sif.out_data}, {31'h0, hold_w});
                if (sif.out_ready) begin
                    if (acc_in_frm == 0) first_cyc = cyc;
                    chk("scoreboard_has_entry", 64'(exq.size() != 0), 64'h1);
                    if (exq.size() != 0) begin
                        exp_w = exq.pop_front();
                        chk($sformatf("word_w%0d", acc_in_frm), {31'h0, sif.out_last, sif.out_data}, {31'h0, exp_w});
                    end
                    acc_in_frm++;
                    hold_vld = 1'b0;
                    if (sif.out_last) begin
                        acc_in_frm = 0;
                        last_cyc   = cyc;
                        seen_frame = 1'b1;
                        idle_gap   = 0;
                    end
                end else begin
                    hold_vld = 1'b1;
                    hold_w   = {sif.out_last, sif.out_data};
                end
            end else begin
                hold_vld = 1'b0;
                idle_gap++;
            end
            prev_valid = sif.out_valid;
        end
    end

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while ((exq.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_in_budget"}, 64'(n < budget), 64'h1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {1'b0, fifo_rden, sif.out_valid, sif.out_last, busy, frame_cnt, hdr_err_cnt, sif.out_data}, 64'h0);
    endtask

    initial begin
        int n;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset_state");
        reset_n = 1'b1;
        enable = 1'b1;
        data_aligned = 1'b1;
        @(negedge clk);

        // 1: one good frame, ready=1
        rden_pulses = 0;
        push_frame(16'hEEAA, 16'hEEBB, 16'hEECC, 16'hEEDD, 1, 1'b0);
        wait_done(200, "t1");
        chk("t1_rden_pulses", 64'(rden_pulses), 64'd1);
        chk("t1_back_to_back_span", 64'(last_cyc - first_cyc), 64'd17);
        chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("t1_hdr_err_cnt", 64'(hdr_err_cnt), 64'd0);

        // 2: same data, ready toggling
        rdy_toggle = 1'b1;
        push_frame(16'hEEAA, 16'hEEBB, 16'hEECC, 16'hEEDD, 1, 1'b0);
        wait_done(300, "t2");
        rdy_toggle = 1'b0;
        chk("t2_stalled_span", 64'(last_cyc - first_cyc), 64'd34);
        chk("t2_frame_cnt", 64'(frame_cnt), 64'd2);

        // 3: bad header on C, then saturation
        push_frame(16'hEEAA, 16'hEEBB, 16'hEE00, 16'hEEDD, 3, 1'b0);
        wait_done(200, "t3a");
        chk("t3_hdr_err_cnt_1", 64'(hdr_err_cnt), 64'd1);
        for (int i = 0; i < 299; i++) begin
            int bad;
            bad = i % 4;
            push_frame(bad == 0 ? 16'h1234 : 16'hEEAA, bad == 1 ? 16'hEEBA : 16'hEEBB,
                       bad == 2 ? 16'h0000 : 16'hEECC, bad == 3 ? 16'hDDEE : 16'hEEDD, 100 + i, 1'b0);
        end
        wait_done(299 * 40, "t3b");
        chk("t3_hdr_err_cnt_sat", 64'(hdr_err_cnt), 64'd255);
        chk("t3_frame_cnt", 64'(frame_cnt), 64'd302);

        // enable / data_aligned gating
        enable = 1'b0;
        push_frame(16'hEEAA, 16'hEEBB, 16'hEECC, 16'hEEDD, 7, 1'b0);
        repeat (8) @(negedge clk);
        chk("gate_enable_busy", 64'(busy), 64'd0);
        enable = 1'b1;
        data_aligned = 1'b0;
        repeat (8) @(negedge clk);
        chk("gate_aligned_busy", {62'h0, busy, sif.out_valid}, 64'd0);
        data_aligned = 1'b1;
        wait_done(200, "gate");
        chk("gate_frame_cnt", 64'(frame_cnt), 64'd303);

        // 4: FIFO C empty holds off the frame
        push_frame(16'hEEAA, 16'hEEBB, 16'hEECC, 16'hEEDD, 9, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4_no_read_while_empty", {59'h0, fifo_rden, sif.out_valid}, 64'h0);
        end
        qc.push_back(held_c);
        n = 0;
        while (fifo_empty != 4'b0000 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!sif.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t4_start_latency", 64'(n), 64'd3);
        wait_done(200, "t4");

        // 5: frame counter wrap
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_cnt;
        mdl_cnt = 16'hFFFF;
        @(negedge clk);
        chk("t5_preload", 64'(frame_cnt), 64'hFFFF);
        push_frame(16'hEEAA, 16'hEEBB, 16'hEECC, 16'hEEDD, 11, 1'b0);
        wait_done(200, "t5");
        chk("t5_wrap", 64'(frame_cnt), 64'd0);

        // 6: reset mid-frame while w7 is presented
        push_frame(16'hEEAA, 16'hEEBB, 16'hEECC, 16'hEEDD, 13, 1'b0);
        n = 0;
        while (acc_in_frm < 7 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("t6_reached_w7", 64'(n < 200), 64'h1);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("t6_reset_outputs");
        exq.delete();
        mdl_cnt = 16'h0000;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t6_after_release");
        push_frame(16'hEEAA, 16'hEEBB, 16'hEECC, 16'hEEDD, 15, 1'b0);
        wait_done(200, "t6");
        chk("t6_frame_cnt", 64'(frame_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
